// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin per tenure, ack routing by outstanding-strobe count.
// Optional feature: define WB_ARB_TIMESLICE_EN to preempt an owner after MAX_BURST strobes.
module wb_arbiter2 #(
    parameter int AW              = 16,
    parameter int DW              = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BURST       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_w,
    output logic [DW-1:0] m0_dat_r,
    output logic          m0_ack,
    output logic          m0_stall,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_w,
    output logic [DW-1:0] m1_dat_r,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_w,
    input  logic [DW-1:0] s_dat_r,
    input  logic          s_ack,
    input  logic          s_stall
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    if (MAX_OUTSTANDING < 1 || MAX_BURST < 1) begin : g_cfg_err
        $error("wb_arbiter2: MAX_OUTSTANDING and MAX_BURST must be at least 1");
    end

    logic [1:0]    state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          own0, own1;
    logic          own_cyc, own_stb, other_cyc;
    logic          cnt_full, own_stall, ack_ok, accept, slice_stop;

    assign own0      = (state == GNT0);
    assign own1      = (state == GNT1);
    assign own_cyc   = own1 ? m1_cyc : m0_cyc;
    assign own_stb   = own1 ? m1_stb : m0_stb;
    assign other_cyc = own1 ? m0_cyc : m1_cyc;
    assign cnt_full  = (cnt == CNT_MAX);

    // Slave cycle stays up for the whole grant, including the drain after the owner drops cyc.
    assign s_cyc   = own0 | own1;
    assign s_stb   = s_cyc & own_cyc & own_stb & ~cnt_full & ~slice_stop;
    assign s_we    = own0 ? m0_we    : (own1 ? m1_we    : 1'b0);
    assign s_adr   = own0 ? m0_adr   : (own1 ? m1_adr   : '0);
    assign s_dat_w = own0 ? m0_dat_w : (own1 ? m1_dat_w : '0);

    assign own_stall = s_stall | cnt_full | slice_stop;
    assign m0_stall  = own0 ? own_stall : 1'b1;
    assign m1_stall  = own1 ? own_stall : 1'b1;

    // An ack with nothing outstanding is spurious and is neither routed nor counted.
    assign ack_ok   = s_ack & (cnt != '0);
    assign m0_ack   = own0 & ack_ok;
    assign m1_ack   = own1 & ack_ok;
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    assign accept = s_stb & ~s_stall;

`ifdef WB_ARB_TIMESLICE_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [BW-1:0] burst;

    assign slice_stop = s_cyc & other_cyc & (burst == BURST_MAX);

    // Saturates so an uncontended owner can stream indefinitely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst <= '0;
        end else if (state_nxt != state && state_nxt != IDLE) begin
            burst <= '0;
        end else if (accept && burst != BURST_MAX) begin
            burst <= burst + BW'(1);
        end
    end
`else
    assign slice_stop = 1'b0;
`endif

    always_comb begin
        cnt_nxt = cnt;
        if (accept && !ack_ok) begin
            cnt_nxt = cnt + CW'(1);
        end else if (!accept && ack_ok) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || last)) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                end
            end
            GNT0: begin
                if ((!m0_cyc || slice_stop) && cnt == '0) begin
                    if (m1_cyc) begin
                        state_nxt = GNT1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GNT1: begin
                if ((!m1_cyc || slice_stop) && cnt == '0) begin
                    if (m0_cyc) begin
                        state_nxt = GNT0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: vector table for grant/handover, hand sequences for
// outstanding limit, drain, spurious ack, async reset and (with WB_ARB_TIMESLICE_EN) preemption.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [15:0] m0_adr, m0_dat_w, m1_adr, m1_dat_w;
    logic [15:0] m0_dat_r, m1_dat_r;
    logic        m0_ack, m0_stall, m1_ack, m1_stall;
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [15:0] s_adr, s_dat_w, s_dat_r;

    logic        hold_ack, spur_ack, ack_r;
    logic [15:0] rdat;
    logic [15:0] adr_q[$];

    int checks = 0;
    int errors = 0;

    wb_arbiter2 #(.AW(16), .DW(16), .MAX_OUTSTANDING(4), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall)
    );

    always #5 clk = ~clk;

    // 1-cycle RAM; acks can be held back to build up outstanding strobes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q.delete();
            ack_r <= 1'b0;
            rdat  <= '0;
        end else begin
            if (s_stb && !s_stall) adr_q.push_back(s_adr);
            if (!hold_ack && adr_q.size() != 0) begin
                ack_r <= 1'b1;
                rdat  <= adr_q.pop_front() ^ 16'hA5A5;
            end else begin
                ack_r <= 1'b0;
            end
        end
    end

    assign s_ack   = ack_r | spur_ack;
    assign s_dat_r = rdat;

    typedef struct {
        logic        m0c, m0s, m1c, m1s;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [21:0] ex(input logic c, input logic s, input logic st0,
                                       input logic st1, input logic a0, input logic a1,
                                       input logic [15:0] adr);
        return {c, s, st0, st1, a0, a1, adr};
    endfunction

    function automatic vec_t mkv(input logic m0c, input logic m0s, input logic m1c,
                                 input logic m1s, input logic [21:0] e);
        vec_t v;
        v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0;
        s_stall = 0; hold_ack = 0; spur_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " s_cyc"}, s_cyc, 0);
        chk({tag, " s_stb"}, s_stb, 0);
        chk({tag, " acks"}, {m0_ack, m1_ack}, 0);
        chk({tag, " stalls"}, {m0_stall, m1_stall}, 2'b11);
        chk({tag, " s_adr/we/dat_w"}, {s_we, s_adr, s_dat_w}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued, acks0, acks1, outst, m0acc;
        logic done;

        rst_n = 0;
        clear_inputs();
        m0_adr = 16'h0010; m0_dat_w = 16'h1111; m0_we = 1;
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        do_reset();

        // Grant, handover and round-robin table (starts right after reset, last=1).
        tbl[0]  = mkv(1, 0, 1, 0, ex(0, 0, 1, 1, 0, 0, 16'h0000));
        tbl[1]  = mkv(1, 1, 1, 0, ex(1, 1, 0, 1, 0, 0, 16'h0010));
        tbl[2]  = mkv(1, 0, 1, 0, ex(1, 0, 0, 1, 1, 0, 16'h0010));
        tbl[3]  = mkv(0, 0, 1, 0, ex(1, 0, 0, 1, 0, 0, 16'h0010));
        tbl[4]  = mkv(0, 0, 1, 1, ex(1, 1, 1, 0, 0, 0, 16'h0200));
        tbl[5]  = mkv(0, 0, 1, 0, ex(1, 0, 1, 0, 0, 1, 16'h0200));
        tbl[6]  = mkv(0, 0, 0, 0, ex(1, 0, 1, 0, 0, 0, 16'h0200));
        tbl[7]  = mkv(1, 0, 1, 0, ex(0, 0, 1, 1, 0, 0, 16'h0000));
        tbl[8]  = mkv(1, 0, 1, 0, ex(1, 0, 0, 1, 0, 0, 16'h0010));
        tbl[9]  = mkv(0, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 16'h0010));
        tbl[10] = mkv(0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0, 16'h0000));
        m0_adr = 16'h0010; m1_adr = 16'h0200;
        for (int i = 0; i < 11; i++) begin
            m0_cyc = tbl[i].m0c; m0_stb = tbl[i].m0s;
            m1_cyc = tbl[i].m1c; m1_stb = tbl[i].m1s;
            @(negedge clk);
            chk($sformatf("vec%0d {cyc,stb,st0,st1,ack0,ack1,adr}", i),
                {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, s_adr}, tbl[i].exp);
            tick();
        end

        // m0 single read then a write.
        do_reset();
        m0_adr = 16'h0010; m0_cyc = 1; m0_stb = 1;
        @(negedge clk);
        chk("rd c0 s_stb", s_stb, 0);
        chk("rd c0 m1_stall", m1_stall, 1);
        tick();
        @(negedge clk);
        chk("rd c1 s_stb/adr", {s_stb, s_we, s_adr}, {2'b10, 16'h0010});
        chk("rd c1 m1_stall", m1_stall, 1);
        tick();
        m0_stb = 0;
        @(negedge clk);
        chk("rd c2 m0_ack", m0_ack, 1);
        chk("rd c2 m0_dat_r", m0_dat_r, 16'hA5B5);
        chk("rd c2 m1_ack/stall", {m1_ack, m1_stall}, 2'b01);
        tick();
        m0_stb = 1; m0_we = 1; m0_adr = 16'h0044; m0_dat_w = 16'h1234;
        @(negedge clk);
        chk("wr s_we/adr/dat", {s_stb, s_we, s_adr, s_dat_w}, {2'b11, 16'h0044, 16'h1234});
        tick();
        m0_stb = 0; m0_we = 0;
        @(negedge clk);
        chk("wr ack", {m0_ack, m1_ack}, 2'b10);
        tick();

        // m1 pipelined strobes against the outstanding limit.
        do_reset();
        issued = 0; acks0 = 0; acks1 = 0;
        for (int i = 0; i < 30; i++) begin
            m1_cyc   = 1;
            m1_stb   = (issued < 6);
            m1_adr   = 16'h0300 + 16'(issued);
            hold_ack = (i < 8);
            s_stall  = (i == 5 || i == 6);
            @(negedge clk);
            outst = issued - acks1;
            if (i >= 1) begin
                chk($sformatf("burst i%0d m1_stall", i), m1_stall, s_stall || outst == 4);
                if (outst == 4) chk($sformatf("burst i%0d s_stb at limit", i), s_stb, 0);
            end
            if (m1_ack) acks1++;
            if (m0_ack) acks0++;
            if (s_stb && !s_stall) issued++;
            tick();
        end
        chk("burst accepted", issued, 6);
        chk("burst acks to m1", acks1, 6);
        chk("burst acks to m0", acks0, 0);
        m1_cyc = 0; m1_stb = 0; s_stall = 0;
        tick();

        // Drain with a waiting competitor, then spurious acks.
        do_reset();
        m0_adr = 16'h0050; m0_cyc = 1; m0_stb = 1; hold_ack = 1;
        tick();
        @(negedge clk);
        chk("drain c1 s_stb", s_stb, 1);
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 1;
        @(negedge clk);
        chk("drain c2 cyc/st1/ack0", {s_cyc, m1_stall, m0_ack}, 3'b110);
        tick();
        hold_ack = 0;
        @(negedge clk);
        chk("drain c3 cyc/st1", {s_cyc, m1_stall}, 2'b11);
        tick();
        @(negedge clk);
        chk("drain c4 ack0/ack1/st1", {m0_ack, m1_ack, m1_stall}, 3'b101);
        tick();
        @(negedge clk);
        chk("drain c5 st1", {s_cyc, m1_stall}, 2'b11);
        tick();
        @(negedge clk);
        chk("drain c6 st0/st1", {m0_stall, m1_stall}, 2'b10);
        tick();
        m1_cyc = 0;
        tick();
        spur_ack = 1;
        @(negedge clk);
        chk("spur idle acks", {s_cyc, m0_ack, m1_ack}, 3'b000);
        tick();
        m1_cyc = 1; m1_stb = 1; hold_ack = 1;
        @(negedge clk);
        chk("spur c9 m1_ack", m1_ack, 0);
        tick();
        @(negedge clk);
        chk("spur gnt cnt0 m1_ack", m1_ack, 0);
        chk("spur c10 s_stb", s_stb, 1);
        tick();
        spur_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("spur fill%0d stb/stall", i), {s_stb, m1_stall}, 2'b10);
            tick();
        end
        @(negedge clk);
        chk("spur cnt full stb/stall", {s_stb, m1_stall}, 2'b01);
        tick();

        // Asynchronous reset with two strobes in flight.
        do_reset();
        m0_adr = 16'h7777; m0_dat_w = 16'h8888; m0_we = 1;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 16'h0400; m1_dat_w = 16'hBEEF;
        hold_ack = 1;
        repeat (3) tick();
        #2;
        rst_n = 0;
        #1;
        chk_reset_outputs("midrst");
        hold_ack = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk("postrst c0 m1_stall", m1_stall, 1);
        tick();
        @(negedge clk);
        chk("postrst c1 stb/stall/adr", {s_stb, m1_stall, s_adr}, {2'b10, 16'h0400});
        tick();

`ifdef WB_ARB_TIMESLICE_EN
        // Preemption after MAX_BURST accepts with a waiting competitor.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0500; m1_cyc = 1; m1_adr = 16'h0600;
        m0acc = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!m1_stall) done = 1;
            else begin
                if (m0acc == 8) chk($sformatf("slice i%0d m0_stall", i), m0_stall, 1);
                if (s_stb && !s_stall && !m0_stall) m0acc++;
            end
            tick();
        end
        chk("slice m1 granted", done, 1);
        chk("slice m0 accepts", m0acc, 8);
        m1_stb = 1; issued = 0;
        for (int i = 0; i < 10 && issued < 2; i++) begin
            @(negedge clk);
            chk($sformatf("slice m1 tenure i%0d m0_stall", i), m0_stall, 1);
            if (s_stb && !s_stall && !m1_stall) issued++;
            tick();
            if (issued == 2) m1_stb = 0;
        end
        m1_cyc = 0; m1_stb = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!m0_stall) done = 1;
            tick();
        end
        chk("slice m0 regrant", done, 1);
        clear_inputs();
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone arbiter for the shared 16-bit single-port RAM behind the RAM wrapper (classic pipelined cycles, 1-cycle ack, never stalls). Master 0 is the J1 data port and master 1 is the DMA/debug port. The arbiter grants the slave to one master per bus tenure, using round-robin between tenures. It tracks in-flight strobes so every ack returns to the master that issued the strobe.

## Interface
Parameters:
- AW, 16: address width.
- DW, 16: data width.
- MAX_OUTSTANDING, 4: maximum accepted strobes not yet acked.
- MAX_BURST, 8: strobes per tenure before preemption. Used only with WB_ARB_TIMESLICE_EN.

Ports (N = 0, 1):
- clk  in  1  bus clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mN_cyc  in  1  master N bus cycle request.
- mN_stb  in  1  master N strobe.
- mN_we  in  1  master N write enable.
- mN_adr  in  AW  master N address.
- mN_dat_w  in  DW  master N write data.
- mN_dat_r  out  DW  read data; equals s_dat_r for both masters.
- mN_ack  out  1  ack, routed to owner only.
- mN_stall  out  1  stall to master N.
- s_cyc  out  1  slave cycle.
- s_stb  out  1  slave strobe.
- s_we  out  1  slave write enable.
- s_adr  out  AW  slave address.
- s_dat_w  out  DW  slave write data.
- s_dat_r  in  DW  slave read data.
- s_ack  in  1  slave ack.
- s_stall  in  1  slave stall.

## Operation
State register: IDLE, GNT0, GNT1.
- last (1 bit): most recent grant.
- cnt (clog2(MAX_OUTSTANDING+1) bits): outstanding strobes.
- burst: strobes in the current tenure (macro only).

Transitions:
- IDLE → GNTn when mN_cyc=1.
- IDLE, both cyc: grant the master ≠ last.
- GNTn → stay while mN_cyc=1.
- GNTn release: mN_cyc=0 and cnt=0. Go to GNT(other) if the other cyc=1, else IDLE.
- mN_cyc drop with cnt>0: hold GNTn and keep routing acks until cnt=0. Slave cyc stays asserted during drain.

Forwarding in GNTn:
- s_cyc = 1 (owner cyc or drain).
- s_stb = mN_stb & mN_cyc & (cnt<MAX_OUTSTANDING).
- s_we, s_adr, s_dat_w mux from master N.
- mN_stall = s_stall | (cnt==MAX_OUTSTANDING).
- Non-owner stall = 1. Both stalls = 1 in IDLE.

Ack and counter:
- mN_ack = s_ack while owner is N. Other ack = 0.
- cnt +1 on accepted strobe (s_stb & ~s_stall).
- cnt −1 on s_ack. Accept and ack in the same cycle: cnt unchanged.
- s_ack with cnt=0 is spurious: dropped, not routed, cnt stays 0.
- last updates on every IDLE/GNT → GNTn entry.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0, burst=0, last=1 (m0 wins first contention). s_cyc=0, s_stb=0, mN_ack=0, mN_stall=1; data/addr outputs 0.
- Grant latency: one cycle after cyc is first seen.
- With the 1-cycle RAM, read/write ack arrives two cycles after the strobe is first presented from IDLE, one cycle after acceptance.
- Back-to-back handover: no dead cycle when the other master is waiting at release.
- Reset mid-tenure: in-flight acks are lost and masters must restart.

## Configuration
WB_ARB_TIMESLICE_EN:
- Defined:
  - burst counts accepted strobes per tenure and clears on grant.
  - When burst==MAX_BURST and the other master has cyc=1, the owner is stalled.
  - Once cnt=0, the grant switches to the other master. The preempted master keeps cyc and sees stall=1 until it is granted again.
  - With no competitor, bursts are unlimited.
- Undefined: no burst counter; tenure lasts until the owner drops cyc. MAX_BURST is ignored.

## Test plan
- m0 single read: m0_cyc/stb at cycle 0, adr 0x0010 → s_stb at cycle 1, m0_ack and RAM data at cycle 2. m1_stall=1 throughout.
- Simultaneous cyc after reset → m0 granted first. After m0 drops cyc (cnt=0), GNT1 on the next cycle with no IDLE gap. Next contention goes to m0.
- m1 issues 6 pipelined strobes with s_stall forced 1 after the 4th accept → m1_stall=1 at cnt=4. Exactly 6 acks reach m1 and none reach m0.
- Owner drops cyc with cnt=1 while m1 waits → grant held until the ack, then switches. Spurious s_ack in IDLE → no mN_ack, cnt stays 0.
- rst_n low mid-burst (cnt=2) → all outputs at reset values immediately. After release, a fresh m1 request is granted in one cycle.
- With WB_ARB_TIMESLICE_EN, MAX_BURST=8: m0 streams continuously, m1 requests → m0 stalled after its 8th accept. m1 granted after the drain, and m0 regains the grant when m1 releases.
